runner_ctrl: RTL and testbench

Parametrised player-character controller, successor to the fixed-geometry dinosaur controller. Sits between the input/timer logic and the sprite renderer and collision unit. Per game tick it runs the character state machine and integrates fixed-point jump physics, with tunable gravity, jump strength and geometry. Ducking is fully implemented, and an optional speed-drop (fast fall) mode can be compiled in.

---
 rtl/runner_ctrl.sv | 178 +++++++++++++++++
 tb/tb_runner_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/runner_ctrl.sv
// runner_ctrl: player-character state machine with fixed-point jump physics and ducking.
// Define RUNNER_SPEED_DROP_EN to compile in the fast-fall (speed-drop) mode.
module runner_ctrl #(
  parameter int POS_W         = 12,
  parameter int FRAC_BITS     = 4,
  parameter int START_X       = 50,
  parameter int GROUND_Y      = 93,
  parameter int HEIGHT        = 47,
  parameter int WIDTH         = 44,
  parameter int HEIGHT_DUCK   = 25,
  parameter int WIDTH_DUCK    = 59,
  parameter int GRAVITY       = 10,
  parameter int INIT_JUMP_VEL = -10,
  parameter int DROP_VEL      = -5,
  parameter int MIN_JUMP_Y    = 63,
  parameter int MAX_JUMP_Y    = 30,
  parameter int SPEED_SHIFT   = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    update,
  input  logic [5:0]              timer,
  input  logic [4:0]              speed,
  input  logic                    jump,
  input  logic                    duck,
  input  logic                    crash,
  input  logic                    restart,
  output logic signed [POS_W-1:0] x_pos,
  output logic signed [POS_W-1:0] y_pos,
  output logic [9:0]              width,
  output logic [9:0]              height,
  output logic [2:0]              state,
  output logic [2:0]              frame
);

  localparam int YW = POS_W + FRAC_BITS;

  localparam logic signed [YW-1:0]    GROUND_FP  = YW'(GROUND_Y * (2 ** FRAC_BITS));
  localparam logic signed [YW-1:0]    DROP_FP    = YW'(DROP_VEL * (2 ** FRAC_BITS));
  localparam logic signed [YW-1:0]    ACCEL      = YW'(GRAVITY);
  localparam logic signed [YW-1:0]    ACCEL_FAST = YW'(3 * GRAVITY);
  localparam logic signed [POS_W-1:0] GROUND_PX  = POS_W'(GROUND_Y);
  localparam logic signed [POS_W-1:0] DUCK_PX    = POS_W'(GROUND_Y + HEIGHT - HEIGHT_DUCK);
  localparam logic signed [POS_W-1:0] MIN_PX     = POS_W'(MIN_JUMP_Y);
  localparam logic signed [POS_W-1:0] MAX_PX     = POS_W'(MAX_JUMP_Y);

  typedef enum logic [2:0] {WAITING, RUNNING, JUMPING, DUCKING, CRASHED} state_t;
  typedef enum logic [2:0] {
    WAITING0, WAITING1, RUNNING0, RUNNING1, JUMPING0, DUCKING0, DUCKING1, CRASHED0
  } frame_t;

  state_t                  state_q, state_d;
  frame_t                  frame_q, frame_d;
  logic signed [YW-1:0]    y_fp, y_fp_d, vel, vel_d;
  logic signed [YW-1:0]    y_sum, vel_acc, jump_vel;
  logic signed [POS_W-1:0] y_px, sum_px, y_pos_d;
  logic                    reached_min, reached_min_d;
  logic                    crash_hit, fast_fall;

`ifdef RUNNER_SPEED_DROP_EN
  assign fast_fall = duck;
`else
  assign fast_fall = 1'b0;
`endif

  assign jump_vel  = YW'((INIT_JUMP_VEL - int'(speed >> SPEED_SHIFT)) * (2 ** FRAC_BITS));
  assign y_sum     = y_fp + vel;
  assign vel_acc   = vel + (fast_fall ? ACCEL_FAST : ACCEL);
  assign y_px      = POS_W'(y_fp >>> FRAC_BITS);
  assign sum_px    = POS_W'(y_sum >>> FRAC_BITS);
  assign crash_hit = crash && (state_q inside {RUNNING, JUMPING, DUCKING});

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    y_fp_d        = y_fp;
    vel_d         = vel;
    reached_min_d = reached_min;
    y_pos_d       = y_pos;
    frame_d       = CRASHED0;

    // NOTE: blocking assignments here, so reached_min_d set below is visible to the clamp test.
    if (crash_hit) begin
      state_d = CRASHED;
    end else if (update) begin
      case (state_q)
        WAITING: if (jump) begin
          state_d = RUNNING;
          y_fp_d  = GROUND_FP;
          vel_d   = '0;
        end
        RUNNING, DUCKING: begin
          if (jump) begin
            state_d       = JUMPING;
            vel_d         = jump_vel;
            reached_min_d = 1'b0;
          end else if (state_q == RUNNING && duck) begin
            state_d = DUCKING;
          end else if (state_q == DUCKING && !duck) begin
            state_d = RUNNING;
            y_fp_d  = GROUND_FP;
            vel_d   = '0;
          end
        end
        JUMPING: begin
          if (y_sum > GROUND_FP) begin
            state_d = duck ? DUCKING : RUNNING;
            y_fp_d  = GROUND_FP;
            vel_d   = '0;
          end else begin
            y_fp_d        = y_sum;
            vel_d         = vel_acc;
            reached_min_d = reached_min || (y_px < MIN_PX);
            if (reached_min_d && !fast_fall && (!jump || sum_px < MAX_PX) && vel_acc < DROP_FP)
              vel_d = DROP_FP;
          end
        end
        CRASHED: if (restart) begin
          state_d       = WAITING;
          y_fp_d        = GROUND_FP;
          vel_d         = '0;
          reached_min_d = 1'b0;
        end
        default: state_d = WAITING;
      endcase
    end

    // The standing-sprite y lives in y_fp; the ducking sprite is bottom-aligned on top of it.
    case (state_d)
      WAITING: begin
        frame_d = (timer >= 6'd30) ? WAITING0 : WAITING1;
        y_pos_d = POS_W'(y_fp_d >>> FRAC_BITS);
      end
      RUNNING: begin
        frame_d = ((timer % 6'd10) < 6'd5) ? RUNNING0 : RUNNING1;
        y_pos_d = POS_W'(y_fp_d >>> FRAC_BITS);
      end
      JUMPING: begin
        frame_d = JUMPING0;
        y_pos_d = POS_W'(y_fp_d >>> FRAC_BITS);
      end
      DUCKING: begin
        frame_d = ((timer % 6'd20) < 6'd10) ? DUCKING0 : DUCKING1;
        y_pos_d = DUCK_PX;
      end
      default: begin
        frame_d = CRASHED0;
        y_pos_d = y_pos;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAITING;
      frame_q     <= WAITING0;
      y_fp        <= GROUND_FP;
      vel         <= '0;
      reached_min <= 1'b0;
      y_pos       <= GROUND_PX;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      y_fp        <= y_fp_d;
      vel         <= vel_d;
      reached_min <= reached_min_d;
      y_pos       <= y_pos_d;
    end
  end

  assign x_pos  = POS_W'(START_X);
  assign state  = state_q;
  assign frame  = frame_q;
  assign width  = (state_q == DUCKING) ? 10'(WIDTH_DUCK)  : 10'(WIDTH);
  assign height = (state_q == DUCKING) ? 10'(HEIGHT_DUCK) : 10'(HEIGHT);

endmodule

// File: tb/tb_runner_ctrl.sv
// tb_runner_ctrl: directed scoreboard bench for runner_ctrl (default build, speed drop disabled).
module tb_runner_ctrl;

  localparam int S_WAIT = 0, S_RUN = 1, S_JUMP = 2, S_DUCK = 3, S_CRASH = 4;
  localparam int F_W0 = 0, F_W1 = 1, F_R0 = 2, F_R1 = 3, F_J0 = 4, F_D0 = 5, F_D1 = 6, F_C0 = 7;
  localparam int GROUND_FP = 93 * 16;

  logic               clk = 1'b0;
  logic               rst, update, jump, duck, crash, restart;
  logic [5:0]         timer;
  logic [4:0]         speed;
  logic signed [11:0] x_pos, y_pos;
  logic [9:0]         width, height;
  logic [2:0]         state, frame;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    int    st;
    int    fr;
    int    y;
  } exp_t;

  exp_t sb[$];

  runner_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .update (update),
    .timer  (timer),
    .speed  (speed),
    .jump   (jump),
    .duck   (duck),
    .crash  (crash),
    .restart(restart),
    .x_pos  (x_pos),
    .y_pos  (y_pos),
    .width  (width),
    .height (height),
    .state  (state),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int frame_of(input int st, input int t);
    case (st)
      S_WAIT:  return (t >= 30) ? F_W0 : F_W1;
      S_RUN:   return ((t % 10) < 5) ? F_R0 : F_R1;
      S_DUCK:  return ((t % 20) < 10) ? F_D0 : F_D1;
      S_JUMP:  return F_J0;
      default: return F_C0;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int st, input int y);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.fr  = frame_of(st, int'(timer));
    e.y   = y;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs, then compare the DUT against the oldest scoreboard entry.
  task automatic cycle(input logic u, input logic j, input logic d, input logic c, input logic r);
    exp_t e;
    update = u; jump = j; duck = d; crash = c; restart = r;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_state"},  int'(state),  e.st);
      check({e.tag, "_frame"},  int'(frame),  e.fr);
      check({e.tag, "_x"},      int'(x_pos),  50);
      check({e.tag, "_y"},      int'(y_pos),  e.y);
      check({e.tag, "_width"},  int'(width),  (e.st == S_DUCK) ? 59 : 44);
      check({e.tag, "_height"}, int'(height), (e.st == S_DUCK) ? 25 : 47);
    end
  endtask

  // Spec-level flight model: ticks every cycle until landing; hold keeps jump up while y >= 63.
  task automatic fly(input string tag, input bit hold, input bit d, input int y0, input int v0);
    int my = y0;
    int mv = v0;
    bit rm = 1'b0;
    bit landed = 1'b0;
    bit released = 1'b0;
    bit j;
    int nxt, prev_px, st, yexp;
    for (int i = 0; i < 80 && !landed; i++) begin
      j   = hold && ((my >>> 4) >= 63);
      nxt = my + mv;
      if (nxt > GROUND_FP) begin
        landed = 1'b1;
        my     = GROUND_FP;
        mv     = 0;
        st     = d ? S_DUCK : S_RUN;
        yexp   = d ? 115 : 93;
      end else begin
        prev_px = my >>> 4;
        my      = nxt;
        mv      = mv + 10;
        if (prev_px < 63) rm = 1'b1;
        if (rm && (!j || (my >>> 4) < 30) && mv < -80) mv = -80;
        st   = S_JUMP;
        yexp = my >>> 4;
      end
      expect_out(tag, st, yexp);
      cycle(1'b1, j, d, 1'b0, 1'b0);
      if (hold && !j && !released) begin
        released = 1'b1;
        check({tag, "_vel_clamp"}, int'(dut.vel), -80);
      end
    end
    check({tag, "_landed"}, int'(landed), 1);
  endtask

  initial begin
    rst = 1'b0; update = 1'b0; jump = 1'b0; duck = 1'b0; crash = 1'b0; restart = 1'b0;
    timer = 6'd40; speed = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state",  int'(state),   S_WAIT);
    check("reset_frame",  int'(frame),   F_W0);
    check("reset_x",      int'(x_pos),   50);
    check("reset_y",      int'(y_pos),   93);
    check("reset_width",  int'(width),   44);
    check("reset_height", int'(height),  47);
    check("reset_vel",    int'(dut.vel), 0);
    rst = 1'b1;

    expect_out("wait_idle_t40", S_WAIT, 93);  cycle(0, 0, 0, 0, 0);
    timer = 6'd10;
    expect_out("wait_tick_t10", S_WAIT, 93);  cycle(1, 0, 0, 0, 0);
    expect_out("start_run", S_RUN, 93);       cycle(1, 1, 0, 0, 0);
    timer = 6'd7;
    expect_out("run_idle_t7", S_RUN, 93);     cycle(0, 0, 0, 0, 0);
    timer = 6'd10;

    expect_out("jump_start", S_JUMP, 93);     cycle(1, 1, 0, 0, 0);
    check("jump_start_vel", int'(dut.vel), -160);
    expect_out("jump_tick1", S_JUMP, 83);     cycle(1, 1, 0, 0, 0);
    check("jump_tick1_vel", int'(dut.vel), -150);
    expect_out("jump_no_tick", S_JUMP, 83);   cycle(0, 1, 0, 0, 0);
    check("jump_no_tick_vel", int'(dut.vel), -150);
    fly("hold_jump", 1'b1, 1'b0, 83 * 16, -150);

    expect_out("duck_enter", S_DUCK, 115);    cycle(1, 0, 1, 0, 0);
    timer = 6'd3;
    expect_out("duck_idle_t3", S_DUCK, 115);  cycle(0, 0, 1, 0, 0);
    timer = 6'd10;
    expect_out("duck_exit", S_RUN, 93);       cycle(1, 0, 0, 0, 0);

    speed = 5'd31;
    expect_out("fast_jump_start", S_JUMP, 93); cycle(1, 1, 0, 0, 0);
    check("fast_jump_start_vel", int'(dut.vel), -208);
    expect_out("fast_jump_tick1", S_JUMP, 80); cycle(1, 1, 0, 0, 0);
    check("fast_jump_tick1_vel", int'(dut.vel), -198);
    expect_out("crash_pulse", S_CRASH, 80);    cycle(0, 0, 0, 1, 0);
    expect_out("crash_frozen", S_CRASH, 80);   cycle(1, 1, 0, 0, 0);
    expect_out("restart_no_tick", S_CRASH, 80); cycle(0, 0, 0, 0, 1);
    expect_out("restart", S_WAIT, 93);         cycle(1, 0, 0, 0, 1);
    check("restart_vel", int'(dut.vel), 0);

    expect_out("rerun", S_RUN, 93);            cycle(1, 1, 0, 0, 0);
    expect_out("jump_over_duck", S_JUMP, 93);  cycle(1, 1, 1, 0, 0);
    fly("duck_flight", 1'b0, 1'b1, GROUND_FP, -208);

    expect_out("crash_over_tick", S_CRASH, 115); cycle(1, 1, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
